bridge_arbiter: RTL and testbench
=================================

// Module: bridge_arbiter
// PURPOSE
//  Two-master arbiter in front of the system Bridge. M0 is the CPU data port (lw/sw, byteen) and M1 is a DMA/debug master.
//  Both masters share the single Bridge path to DM, Timer0 (0x7f00), Timer1 (0x7f10) and the interrupt generator (0x7f20).
//  Ownership is granted per burst, with round-robin tie-break and a bounded burst length for fairness.
//  Read data is registered back to the owning master.
// PARAMETERS
//  MAX_BURST  4  beats a master may keep the bus while the other master is requesting (>=1)
//  CW         3  width of the beat counter; must satisfy 2^CW > MAX_BURST
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  m0_req     in   1   M0 requests a beat this cycle (held high for a burst)
//  m0_addr    in   32  M0 byte address
//  m0_wdata   in   32  M0 write data
//  m0_byteen  in   4   M0 byte enables: nonzero = write, 0 = read
//  m0_gnt     out  1   M0 owns the bus; a beat occurs when m0_req && m0_gnt
//  m0_rdata   out  32  read data for M0's last read beat
//  m0_rvalid  out  1   m0_rdata valid (one-cycle pulse)
//  m1_*       same set as m0_* for M1
//  s_addr     out  32  to Bridge b_adress
//  s_wdata    out  32  to Bridge b_Wdata
//  s_byteen   out  4   to Bridge b_byteen
//  s_rdata    in   32  from Bridge b_Rdata (combinational on s_addr)
// BEHAVIOUR
//  Reset (async): state=IDLE, m0_gnt=m1_gnt=0, m*_rvalid=0, m*_rdata=0, beat count=0, last_owner=M1 (so M0 wins the first tie).
//  States: IDLE, OWN0, OWN1. gnt is a registered decode of state: m0_gnt=(OWN0), m1_gnt=(OWN1).
//  IDLE: only mX_req -> OWNX. Both -> OWN of the master != last_owner. None -> stay.
//    Grant latency is 1 cycle from the first req seen in IDLE.
//  OWNx, beat = mx_req this cycle; cnt increments per beat and records last_owner=x.
//    !mx_req: other req -> OWN(other) with cnt=0; else -> IDLE.
//    mx_req && cnt==MAX_BURST-1 (this beat is the MAX_BURST-th): other req -> OWN(other); else stay in OWNx.
//      cnt=0 in both cases.
//    otherwise stay in OWNx.
//  Handover is zero-bubble: old gnt falls and new gnt rises on the same edge.
//  Slave drive (combinational):
//    mux selected by owner when a beat occurs, else s_addr=0, s_wdata=0, s_byteen=0.
//    The arbiter never issues a write without a beat.
//  Read return: on a read beat (byteen==0), s_rdata is captured into mX_rdata at the edge.
//    mX_rvalid=1 for exactly the following cycle. A write beat gives rvalid=0. rdata holds between reads.
//  Read-then-switch: rvalid still goes to the master that issued the read, even if gnt has moved.
//  Addresses pass unmodified; decode and range checks stay in the Bridge.
//  Reset mid-burst: the in-flight beat is discarded, no rvalid is produced, and everything returns to reset values immediately.
// TESTING
//  T1 M0 read alone: m0_req@c0 addr=0x100 byteen=0 -> m0_gnt=1@c1, s_addr=0x100@c1, m0_rvalid=1@c2, m0_rdata=s_rdata sampled @c1.
//  T2 M1 write alone: addr=0x7f00 wdata=0xdeadbeef byteen=0xF -> s_byteen=0xF, s_wdata=0xdeadbeef only @c1, m1_rvalid stays 0.
//  T3 both hold req from reset, MAX_BURST=4 -> M0 4 beats, M1 4 beats, M0 4 ...; no idle cycle at handovers.
//  T4 M0 holds req 10 cycles, M1 idle -> m0_gnt continuously 1 for 10 beats, then IDLE one cycle after m0_req falls.
//  T5 M0 drops req after 2 beats while M1 waiting -> m1_gnt rises on the next edge; m0_rvalid for M0's last read still arrives.
//  T6 reset asserted mid-burst in OWN1 -> m1_gnt=0 and all rvalid=0 at once; after release with both req, M0 is granted first.

Source files
------------

// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Two-master arbiter in front of the system Bridge. M0 is the CPU data
//   port and M1 is a DMA/debug master. Ownership is granted per burst.
//   Ties are broken round-robin. A burst is capped at MAX_BURST beats
//   while the other master is waiting. Read data is registered back to
//   the master that issued the read.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   mX_req                  master X requests a beat (held high for a burst)
//   mX_addr/wdata/byteen    master X beat; byteen != 0 is a write, 0 is a read
//   mX_gnt                  master X owns the bus; beat = mX_req && mX_gnt
//   mX_rdata/rvalid         read return; rvalid pulses for one cycle
//   s_addr/wdata/byteen     to the Bridge; all zero when no beat occurs
//   s_rdata                 from the Bridge, combinational on s_addr
//
// Handshake: a beat is transferred in any cycle where mX_req && mX_gnt.
// Grant is a registered function of the arbitration state. A master may
// change addr/wdata/byteen every beat. Read data returns on the cycle after
// the read beat, with rvalid high for exactly that cycle.

module bridge_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CW        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_owner, last_owner_nxt;   // 0 = M0, 1 = M1
    logic          beat0, beat1;

    assign beat0 = (state == OWN0) && m0_req;
    assign beat1 = (state == OWN1) && m1_req;

    // Next-state logic. The burst counter only limits ownership when the
    // other master is waiting; otherwise it wraps and the owner stays.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (m0_req && m1_req) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_nxt = OWN0;
                end else if (m1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    cnt_nxt   = '0;
                    state_nxt = m1_req ? OWN1 : IDLE;
                end else begin
                    last_owner_nxt = 1'b0;
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (m1_req) state_nxt = OWN1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    cnt_nxt   = '0;
                    state_nxt = m0_req ? OWN0 : IDLE;
                end else begin
                    last_owner_nxt = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (m0_req) state_nxt = OWN0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Grants are registered from the next state so they toggle cleanly on
    // the same edge as the state; a handover costs no idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
            m0_gnt     <= (state_nxt == OWN0);
            m1_gnt     <= (state_nxt == OWN1);
        end
    end

    // Read return is tagged by the beat, not by the current grant, so a
    // read issued just before a handover still returns to its issuer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= beat0 && (m0_byteen == 4'b0);
            m1_rvalid <= beat1 && (m1_byteen == 4'b0);
            if (beat0 && (m0_byteen == 4'b0)) m0_rdata <= s_rdata;
            if (beat1 && (m1_byteen == 4'b0)) m1_rdata <= s_rdata;
        end
    end

    // Slave side is driven only during a beat, so no stray write can leak
    // out while a grant is held without a request.
    always_comb begin
        s_addr   = '0;
        s_wdata  = '0;
        s_byteen = '0;
        if (beat0) begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_byteen = m0_byteen;
        end else if (beat1) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_byteen = m1_byteen;
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter
//   Directed bench for bridge_arbiter (MAX_BURST = 4). Inputs change 1 time
//   unit after the rising edge; outputs are sampled on the falling edge.
//   The Bridge is modelled as a fixed combinational function of s_addr.

module tb_bridge_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_byteen;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] bridge_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign s_rdata = bridge_model(s_addr);

    bridge_arbiter #(.MAX_BURST(4), .CW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_byteen (m0_byteen),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_byteen (m1_byteen),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_byteen  (s_byteen),
        .s_rdata   (s_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] prev;

        idle_inputs();
        reset = 1'b1;
        repeat (3) next_cycle();
        sample();
        check("rst_gnt",   {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_rvalid",{30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_rdata0", m0_rdata, 32'd0);
        check("rst_rdata1", m1_rdata, 32'd0);
        check("rst_saddr",  s_addr, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // T1: single M0 read
        m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
        sample();
        check("t1_gnt_c0", {31'd0, m0_gnt}, 32'd0);
        check("t1_saddr_c0", s_addr, 32'd0);
        next_cycle();
        sample();
        check("t1_gnt_c1", {31'd0, m0_gnt}, 32'd1);
        check("t1_saddr_c1", s_addr, 32'h100);
        check("t1_byteen_c1", {28'd0, s_byteen}, 32'd0);
        next_cycle();
        m0_req = 1'b0;
        sample();
        check("t1_rvalid_c2", {31'd0, m0_rvalid}, 32'd1);
        check("t1_rdata_c2", m0_rdata, 32'h0100_feff);
        check("t1_rvalid1_c2", {31'd0, m1_rvalid}, 32'd0);
        check("t1_saddr_c2", s_addr, 32'd0);
        next_cycle();
        sample();
        check("t1_gnt_c3", {31'd0, m0_gnt}, 32'd0);
        check("t1_rvalid_c3", {31'd0, m0_rvalid}, 32'd0);
        check("t1_rdata_hold", m0_rdata, 32'h0100_feff);
        next_cycle();

        // T2: single M1 write
        m1_req = 1'b1; m1_addr = 32'h7f00; m1_wdata = 32'hdeadbeef; m1_byteen = 4'hf;
        sample();
        check("t2_byteen_c0", {28'd0, s_byteen}, 32'd0);
        check("t2_wdata_c0", s_wdata, 32'd0);
        next_cycle();
        sample();
        check("t2_gnt_c1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("t2_byteen_c1", {28'd0, s_byteen}, 32'hf);
        check("t2_wdata_c1", s_wdata, 32'hdeadbeef);
        check("t2_saddr_c1", s_addr, 32'h7f00);
        next_cycle();
        m1_req = 1'b0;
        sample();
        check("t2_rvalid_c2", {31'd0, m1_rvalid}, 32'd0);
        check("t2_byteen_c2", {28'd0, s_byteen}, 32'd0);
        check("t2_wdata_c2", s_wdata, 32'd0);
        next_cycle();
        sample();
        check("t2_gnt_c3", {31'd0, m1_gnt}, 32'd0);
        check("t2_rdata1", m1_rdata, 32'd0);

        // T3: both request through reset; bursts of 4 alternate, M0 first
        next_cycle();
        reset = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h200; m0_byteen = 4'h0;
        m1_req = 1'b1; m1_addr = 32'h7f10; m1_wdata = 32'h1234_5678; m1_byteen = 4'hf;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        exp_q.push_back(32'd0);
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back((r % 2 == 0) ? 32'd1 : 32'd2);
        prev = 32'd0;
        for (int k = 0; k < 17; k++) begin
            sample();
            e = exp_q.pop_front();
            check("t3_gnt", {30'd0, m1_gnt, m0_gnt}, e);
            check("t3_rvalid0", {31'd0, m0_rvalid}, (prev == 32'd1) ? 32'd1 : 32'd0);
            check("t3_rvalid1", {31'd0, m1_rvalid}, 32'd0);
            check("t3_saddr", s_addr, (e == 32'd1) ? 32'h200 : (e == 32'd2) ? 32'h7f10 : 32'd0);
            prev = e;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        // T4: M0 alone for 10 write beats; burst cap does not cut it off
        m0_req = 1'b1; m0_addr = 32'h400; m0_byteen = 4'h3; m0_wdata = 32'd0;
        sample();
        check("t4_gnt_c0", {31'd0, m0_gnt}, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            m0_wdata = i;
            sample();
            check("t4_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
            check("t4_wdata", s_wdata, i);
            check("t4_byteen", {28'd0, s_byteen}, 32'h3);
        end
        next_cycle();
        m0_req = 1'b0;
        sample();
        check("t4_gnt_drop", {31'd0, m0_gnt}, 32'd1);
        check("t4_byteen_drop", {28'd0, s_byteen}, 32'd0);
        check("t4_rvalid", {31'd0, m0_rvalid}, 32'd0);
        check("t4_rdata_hold", m0_rdata, 32'h0200_fdff);
        next_cycle();
        sample();
        check("t4_gnt_idle", {31'd0, m0_gnt}, 32'd0);

        // T5: M0 drops after two read beats while M1 waits
        next_cycle();
        m0_req = 1'b1; m0_addr = 32'h300; m0_byteen = 4'h0;
        next_cycle();
        m1_req = 1'b1; m1_addr = 32'h7f20; m1_byteen = 4'h0;
        sample();
        check("t5_gnt_c1", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("t5_saddr_c1", s_addr, 32'h300);
        next_cycle();
        m0_addr = 32'h304;
        sample();
        check("t5_saddr_c2", s_addr, 32'h304);
        check("t5_rvalid_c2", {31'd0, m0_rvalid}, 32'd1);
        check("t5_rdata_c2", m0_rdata, 32'h0300_fcff);
        next_cycle();
        m0_req = 1'b0;
        sample();
        check("t5_gnt_c3", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        check("t5_saddr_c3", s_addr, 32'd0);
        check("t5_rvalid_c3", {31'd0, m0_rvalid}, 32'd1);
        check("t5_rdata_c3", m0_rdata, 32'h0304_fcfb);
        next_cycle();
        sample();
        check("t5_gnt_c4", {30'd0, m1_gnt, m0_gnt}, 32'd2);
        check("t5_rvalid_c4", {31'd0, m0_rvalid}, 32'd0);
        check("t5_saddr_c4", s_addr, 32'h7f20);

        // T6: reset in the middle of M1's burst
        next_cycle();
        check("t6_rvalid1_pre", {31'd0, m1_rvalid}, 32'd1);
        check("t6_rdata1_pre", m1_rdata, 32'h7f20_80df);
        #1;
        reset  = 1'b1;
        m0_req = 1'b1;
        #1;
        check("t6_gnt_rst", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("t6_rvalid_rst", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("t6_rdata1_rst", m1_rdata, 32'd0);
        check("t6_saddr_rst", s_addr, 32'd0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("t6_gnt_rel", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("t6_rvalid_rel", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        next_cycle();
        sample();
        check("t6_gnt_first", {30'd0, m1_gnt, m0_gnt}, 32'd1);

        idle_inputs();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
